pc_ctrl: RTL

Multi-cycle fetch/PC sequencer for the NPC core. It issues instruction-fetch requests at the current PC over a valid/ready handshake and hands each fetched instruction to decode. On execute completion it computes the next PC: sequential, branch/jump, trap, or `mret`. It then drives the write enable and next value of the PC register, which resets to 0x8000_0000.

---
 rtl/pc_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pc_ctrl.sv
// Fetch/PC sequencer: fetches at pc, hands each instruction to decode, and selects the next PC when execute completes.
// Latency: 3 cycles per instruction (REQ, RSP, EXEC) with zero-wait memory and single-cycle execute.
// Backpressure: holds the request until ifu_req_ready; waits in RSP for data; bus_err + HALT after TIMEOUT RSP cycles.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   pc / pc_we, next_pc PC register read value / write enable and write data
//   ifu_req_*           fetch request channel (valid/ready, address = pc)
//   ifu_rsp_*           fetch response channel (valid/ready, instruction word)
//   inst, inst_valid    registered instruction to decode and its one-cycle "new" pulse
//   exu_*, trap, mtvec,
//   mret, mepc, halt    execute completion and control-flow information, sampled only in EXEC
//   misalign_exc        one-cycle pulse: redirect/return target misaligned, diverted to the trap vector
//   bus_err             sticky fetch timeout flag
//   halted              controller is parked in HALT
module pc_ctrl #(
    parameter bit          TRAP_ALIGN = 1'b1,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_we,
    output logic [31:0] next_pc,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_addr,
    input  logic        ifu_rsp_valid,
    output logic        ifu_rsp_ready,
    input  logic [31:0] ifu_rsp_inst,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        exu_done,
    input  logic        exu_redirect,
    input  logic [31:0] exu_target,
    input  logic        trap,
    input  logic [31:0] mtvec,
    input  logic        mret,
    input  logic [31:0] mepc,
    input  logic        halt,
    output logic        misalign_exc,
    output logic        bus_err,
    output logic        halted
);

    // Counter just wide enough to hold TIMEOUT.
    localparam int unsigned CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RSP,
        S_EXEC,
        S_HALT
    } state_t;

    state_t        state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [31:0]   inst_q,     inst_d;
    logic          inst_vld_q, inst_vld_d;
    logic          bus_err_q,  bus_err_d;

    logic [CW-1:0] cnt_inc;
    logic          done_fire;

    // ------------------------------------------------------------------
    // Next-PC selection (only meaningful in the exu_done cycle)
    // ------------------------------------------------------------------
    logic [31:0] tvec_aligned;
    logic [31:0] pc_seq;
    logic [31:0] npc_sel;
    logic        tgt_chk;
    logic        misaligned;

    // Masking keeps every mtvec bit in the expression; the low two bits
    // are simply forced to zero.
    assign tvec_aligned = mtvec & 32'hFFFF_FFFC;
    // Plain 32-bit add: 0xFFFF_FFFC wraps to 0.
    assign pc_seq       = pc + 32'd4;

    always_comb begin
        npc_sel = pc_seq;
        tgt_chk = 1'b0;
        if (trap) begin
            // The trap vector is aligned by construction, so never checked.
            npc_sel = tvec_aligned;
        end else if (mret) begin
            npc_sel = mepc;
            tgt_chk = 1'b1;
        end else if (exu_redirect) begin
            npc_sel = exu_target;
            tgt_chk = 1'b1;
        end
    end

    // Only software-supplied targets (mepc / branch target) can be misaligned.
    assign misaligned = TRAP_ALIGN && tgt_chk && (npc_sel[1:0] != 2'b00);

    assign done_fire    = (state_q == S_EXEC) && exu_done;
    assign pc_we        = done_fire;
    assign misalign_exc = done_fire && misaligned;
    // next_pc is don't-care without pc_we; drive 0 so idle outputs stay quiet.
    assign next_pc      = !done_fire ? 32'h0 :
                          misaligned ? tvec_aligned : npc_sel;

    // ------------------------------------------------------------------
    // Handshake outputs decoded from the state register
    // ------------------------------------------------------------------
    assign ifu_req_valid = (state_q == S_REQ);
    // pc is held by the PC register while we sit in REQ, so the address
    // is stable until the request is accepted.
    assign ifu_addr      = (state_q == S_REQ) ? pc : 32'h0;
    // Ready only in RSP: responses arriving after an abandoned fetch are dropped.
    assign ifu_rsp_ready = (state_q == S_RSP);

    assign inst       = inst_q;
    assign inst_valid = inst_vld_q;
    assign bus_err    = bus_err_q;
    assign halted     = (state_q == S_HALT);

    assign cnt_inc = cnt_q + CW'(1);

    // ------------------------------------------------------------------
    // Sequencer next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inst_d     = inst_q;
        inst_vld_d = 1'b0;          // pulse: high only in the first EXEC cycle
        bus_err_d  = bus_err_q;     // sticky until reset

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (ifu_req_ready) begin
                    state_d = S_RSP;
                    cnt_d   = '0;
                end
            end

            S_RSP: begin
                if (ifu_rsp_valid) begin
                    inst_d     = ifu_rsp_inst;
                    inst_vld_d = 1'b1;
                    state_d    = S_EXEC;
                end else begin
                    cnt_d = cnt_inc;
                    // Comparing the incremented value flags the error at the
                    // very edge where the count reaches TIMEOUT.
                    if (cnt_inc >= TO_LIM) begin
                        bus_err_d = 1'b1;
                        state_d   = S_HALT;
                    end
                end
            end

            S_EXEC: begin
                if (exu_done) begin
                    state_d = halt ? S_HALT : S_REQ;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            inst_q     <= 32'h0;
            inst_vld_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inst_q     <= inst_d;
            inst_vld_q <= inst_vld_d;
            bus_err_q  <= bus_err_d;
        end
    end

endmodule
